rpi_byte_collector: RTL and testbench
=====================================

// Module: rpi_byte_collector
// PURPOSE
//  Receive side of the Raspberry Pi 3 link, upstream of the SEED core.
//  - Samples 8-bit bytes from the RPi pins on each rising edge of the RPi load strobe.
//  - Assembles 16 bytes into one 128-bit block and hands it to the SEED core over valid/ready.
//  - Double-buffered: the next block can be collected while the current block waits for the core.
//  - Byte order matches the transmit side: first byte received -> blk_data[127:120].
// PARAMETERS
//  NBYTES       16        bytes per block; blk_data width = 8*NBYTES
//  SYNC_STAGES  2         flip-flop synchronizer depth on rpi_load, rpi_start, rpi_data
//  TIMEOUT_CYC  22'h3FFFFF  idle cycles allowed between bytes of one block (~42 ms at 100 MHz)
//  DEBOUNCE_CYC 100000    stable cycles required on rpi_load (used only with LOAD_DEBOUNCE_EN)
// PORTS
//  clk          in   1    internal 100 MHz clock
//  reset        in   1    asynchronous, active-low reset
//  rpi_data     in   8    byte pins driven by the RPi; asynchronous to clk
//  rpi_load     in   1    RPi strobe; rising edge = byte valid; pulses of >= 20 ms
//  rpi_start    in   1    RPi level; rising edge marks the start of a new message
//  blk_data     out  128  assembled block; stable while blk_valid=1
//  blk_valid    out  1    block available to the SEED core
//  blk_ready    in   1    SEED core accepts the block when blk_valid & blk_ready
//  blk_first    out  1    qualifies blk_data as the first block of a message
//  overflow     out  1    sticky; a byte was dropped because both buffers were full
//  timeout_err  out  1    sticky; a partial block was discarded after TIMEOUT_CYC
//  rx_busy      out  1    high while a partial block (1..NBYTES-1 bytes) is held
// BEHAVIOUR
//  Reset (reset=0, async): all outputs 0, byte count 0, state IDLE, synchronizers 0.
//  Sync/edge detection:
//  - rpi_data passes through the same SYNC_STAGES as rpi_load, so both stay aligned.
//  - load_pe = sync_load & ~sync_load_d; start_pe is formed the same way from rpi_start.
//  - Latency: a pin edge produces load_pe SYNC_STAGES+1 clk cycles later.
//  FSM states: IDLE (count=0), COLLECT (count 1..NBYTES-1), HOLD (shift register full, output busy).
//  - IDLE --load_pe--> COLLECT, with the byte shifted in (shift reg <<8 | byte) and count=1.
//  - COLLECT --load_pe--> shift in and count+1.
//  - On the NBYTES-th byte:
//    - if the output is empty, or accepted in this cycle: copy to blk_data, set blk_valid=1
//      on the next cycle, go to IDLE;
//    - otherwise go to HOLD.
//  - HOLD --output accepted--> transfer on the next cycle, go to IDLE.
//  - HOLD --load_pe--> drop the byte and set overflow=1.
//  - COLLECT: no load_pe for TIMEOUT_CYC cycles -> clear count, set timeout_err=1, go to IDLE.
//  Output handshake:
//  - blk_valid falls the cycle after blk_valid & blk_ready, unless a refill happens in that same cycle.
//  - A refill in the accept cycle keeps blk_valid=1 with the new data, with no bubble.
//  blk_first:
//  - Set in the block assembled after reset or after start_pe; cleared in every later block.
//  - It travels with its block through HOLD.
//  start_pe:
//  - Discards any partial block (count=0, go to IDLE) and clears overflow and timeout_err.
//  - A block already in blk_data or HOLD is kept.
//  - start_pe together with load_pe: the start is applied first, then that byte becomes byte 0.
//  Timeout counter: saturates; resets on every load_pe; counts only in COLLECT.
// CONFIGURATION
//  LOAD_DEBOUNCE_EN defined:
//  - sync_load must hold one value for DEBOUNCE_CYC consecutive cycles before the
//    filtered level changes.
//  - load_pe is formed from the filtered level, which adds DEBOUNCE_CYC cycles of latency.
//  - rpi_data is sampled when the filtered edge occurs.
//  LOAD_DEBOUNCE_EN not defined: load_pe comes straight from sync_load, and DEBOUNCE_CYC is unused.
// STRUCTURE
//  Shared package/header:
//  - state encoding localparams (IDLE/COLLECT/HOLD);
//  - SEED block width constant (128) and byte width (8), shared with the transmit side.
//  Sub-module rpi_pin_sync:
//  - parameterised N-stage synchronizer plus rising-edge detector;
//  - the optional debounce filter lives inside it under LOAD_DEBOUNCE_EN;
//  - instantiated for the load/data bundle and for start.
// TESTING
//  1. 16 load pulses carrying bytes 8'h00..8'h0F, blk_ready=1 ->
//     blk_data=128'h000102..0F, blk_valid high one cycle, blk_first=1.
//  2. blk_ready=0 while 32 bytes are sent ->
//     first block held stable, state HOLD, overflow=0.
//     A 33rd byte -> overflow=1; raise blk_ready -> both blocks delivered in order.
//  3. 5 bytes, then no pulses for TIMEOUT_CYC+1 cycles -> timeout_err=1, rx_busy=0.
//     Next 16 bytes assemble cleanly.
//  4. 7 bytes, then a rpi_start rising edge, then 16 bytes 8'hA0..8'hAF ->
//     block = A0..AF, blk_first=1, and overflow/timeout_err are cleared.
//  5. reset driven low mid-block, asynchronously ->
//     all outputs 0 immediately; count 0 after release.
//  6. LOAD_DEBOUNCE_EN: a 10-cycle glitch on rpi_load -> no byte captured.
//     A clean pulse -> exactly one byte captured.

Source files
------------

// File: rtl/rpi_byte_collector_pkg.sv
// Shared constants for the RPi <-> SEED link: block/byte widths and
// collector state encoding.
package rpi_byte_collector_pkg;

   localparam int SEED_BLK_W = 128;
   localparam int BYTE_W     = 8;

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_COLLECT = 2'd1;
   localparam logic [1:0] S_HOLD    = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE    = S_IDLE,
      ST_COLLECT = S_COLLECT,
      ST_HOLD    = S_HOLD
   } state_e;

endpackage

// File: rtl/rpi_pin_sync.sv
// N-stage synchronizer for a strobe plus its data bundle, with rising-edge
// detect; optional strobe debounce filter under LOAD_DEBOUNCE_EN.
module rpi_pin_sync #(
   parameter int STAGES  = 2,
   parameter int DW      = 8,
   parameter bit FILT    = 1'b0,
   parameter int DEB_CYC = 100000
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          lvl_i,
   input  logic [DW-1:0] data_i,
   output logic          pe_o,
   output logic [DW-1:0] data_o
);

   logic [STAGES-1:0][DW:0] sync_q, sync_d;
   logic                    prev_q, prev_d;
   logic                    sync_lvl;
   logic                    filt_lvl;

   assign sync_lvl = sync_q[STAGES-1][DW];
   assign data_o   = sync_q[STAGES-1][DW-1:0];

   always_comb begin
      sync_d    = sync_q;
      sync_d[0] = {lvl_i, data_i};
      for (int i = 1; i < STAGES; i++) sync_d[i] = sync_q[i-1];
      prev_d = filt_lvl;
      pe_o   = filt_lvl & ~prev_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

`ifdef LOAD_DEBOUNCE_EN
   localparam int DCW = $clog2(DEB_CYC + 1);

   logic [DCW-1:0] deb_q, deb_d;
   logic           flt_q, flt_d;

   // Level must differ from the filtered value for DEB_CYC straight cycles
   always_comb begin
      deb_d = '0;
      flt_d = flt_q;
      if (sync_lvl != flt_q) begin
         if (deb_q >= DCW'(DEB_CYC - 1)) flt_d = sync_lvl;
         else deb_d = deb_q + DCW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         deb_q <= '0;
         flt_q <= 1'b0;
      end else begin
         deb_q <= deb_d;
         flt_q <= flt_d;
      end
   end

   assign filt_lvl = FILT ? flt_q : sync_lvl;
`else
   localparam int unused_deb_cyc = DEB_CYC;
   localparam bit unused_filt    = FILT;

   assign filt_lvl = sync_lvl;
`endif

endmodule

// File: rtl/rpi_byte_collector.sv
// Collects RPi bytes into double-buffered SEED blocks over valid/ready.
// Define LOAD_DEBOUNCE_EN to debounce the rpi_load strobe.
module rpi_byte_collector
   import rpi_byte_collector_pkg::*;
#(
   parameter int          NBYTES       = SEED_BLK_W / BYTE_W,
   parameter int          SYNC_STAGES  = 2,
   parameter int unsigned TIMEOUT_CYC  = 32'h3FFFFF,
   parameter int          DEBOUNCE_CYC = 100000
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [BYTE_W-1:0]        rpi_data,
   input  logic                     rpi_load,
   input  logic                     rpi_start,
   output logic [NBYTES*BYTE_W-1:0] blk_data,
   output logic                     blk_valid,
   input  logic                     blk_ready,
   output logic                     blk_first,
   output logic                     overflow,
   output logic                     timeout_err,
   output logic                     rx_busy
);

   localparam int BW = NBYTES * BYTE_W;
   localparam int CW = $clog2(NBYTES + 1);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   logic              load_pe, start_pe;
   logic [BYTE_W-1:0] rx_byte;
   logic [0:0]        start_unused;

   rpi_pin_sync #(
      .STAGES (SYNC_STAGES),
      .DW     (BYTE_W),
      .FILT   (1'b1),
      .DEB_CYC(DEBOUNCE_CYC)
   ) u_load_sync (
      .clk   (clk),
      .reset (reset),
      .lvl_i (rpi_load),
      .data_i(rpi_data),
      .pe_o  (load_pe),
      .data_o(rx_byte)
   );

   rpi_pin_sync #(
      .STAGES (SYNC_STAGES),
      .DW     (1),
      .FILT   (1'b0),
      .DEB_CYC(DEBOUNCE_CYC)
   ) u_start_sync (
      .clk   (clk),
      .reset (reset),
      .lvl_i (rpi_start),
      .data_i(1'b0),
      .pe_o  (start_pe),
      .data_o(start_unused)
   );

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d, cnt_n;
   logic [TW-1:0]   tmo_q, tmo_d;
   logic [BW-1:0]   shift_q, shift_d;
   logic [BW-1:0]   blk_data_q, blk_data_d;
   logic            blk_valid_q, blk_valid_d;
   logic            blk_first_q, blk_first_d;
   logic            hold_first_q, hold_first_d;
   logic            first_pend_q, first_pend_d;
   logic            ovf_q, ovf_d;
   logic            tmo_err_q, tmo_err_d;
   logic            acc, out_free;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      cnt_n        = '0;
      tmo_d        = tmo_q;
      shift_d      = shift_q;
      blk_data_d   = blk_data_q;
      blk_valid_d  = blk_valid_q;
      blk_first_d  = blk_first_q;
      hold_first_d = hold_first_q;
      first_pend_d = first_pend_q;
      ovf_d        = ovf_q;
      tmo_err_d    = tmo_err_q;
      acc          = blk_valid_q & blk_ready;
      out_free     = ~blk_valid_q | acc;

      if (acc) blk_valid_d = 1'b0;

      // Start drops only the partial block; a held full block survives
      if (start_pe) begin
         ovf_d        = 1'b0;
         tmo_err_d    = 1'b0;
         first_pend_d = 1'b1;
         cnt_d        = '0;
         tmo_d        = '0;
         if (state_q != ST_HOLD) state_d = ST_IDLE;
      end

      if (state_d == ST_HOLD && out_free) begin
         blk_data_d  = shift_q;
         blk_valid_d = 1'b1;
         blk_first_d = hold_first_q;
         state_d     = ST_IDLE;
      end

      if (load_pe) begin
         if (state_d == ST_HOLD) begin
            ovf_d = 1'b1;
         end else begin
            shift_d = {shift_q[BW-BYTE_W-1:0], rx_byte};
            cnt_n   = cnt_d + CW'(1);
            tmo_d   = '0;
            if (cnt_n == CW'(NBYTES)) begin
               cnt_d = '0;
               if (!blk_valid_d) begin
                  blk_data_d  = shift_d;
                  blk_valid_d = 1'b1;
                  blk_first_d = first_pend_d;
                  state_d     = ST_IDLE;
               end else begin
                  hold_first_d = first_pend_d;
                  state_d      = ST_HOLD;
               end
               first_pend_d = 1'b0;
            end else begin
               cnt_d   = cnt_n;
               state_d = ST_COLLECT;
            end
         end
      end else if (state_d == ST_COLLECT) begin
         if (tmo_q >= TW'(TIMEOUT_CYC)) begin
            cnt_d     = '0;
            tmo_d     = '0;
            tmo_err_d = 1'b1;
            state_d   = ST_IDLE;
         end else begin
            tmo_d = tmo_q + TW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         tmo_q        <= '0;
         shift_q      <= '0;
         blk_data_q   <= '0;
         blk_valid_q  <= 1'b0;
         blk_first_q  <= 1'b0;
         hold_first_q <= 1'b0;
         first_pend_q <= 1'b1;
         ovf_q        <= 1'b0;
         tmo_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         tmo_q        <= tmo_d;
         shift_q      <= shift_d;
         blk_data_q   <= blk_data_d;
         blk_valid_q  <= blk_valid_d;
         blk_first_q  <= blk_first_d;
         hold_first_q <= hold_first_d;
         first_pend_q <= first_pend_d;
         ovf_q        <= ovf_d;
         tmo_err_q    <= tmo_err_d;
      end
   end

   assign blk_data    = blk_data_q;
   assign blk_valid   = blk_valid_q;
   assign blk_first   = blk_first_q;
   assign overflow    = ovf_q;
   assign timeout_err = tmo_err_q;
   assign rx_busy     = (state_q == ST_COLLECT);

endmodule

// File: tb/tb_rpi_byte_collector.sv
// Directed bench for rpi_byte_collector with a block scoreboard.
module tb_rpi_byte_collector;
   import rpi_byte_collector_pkg::*;

   localparam int TMO = 200;
   localparam int DEB = 20;

   logic         clk = 1'b0;
   logic         reset;
   logic [7:0]   rpi_data;
   logic         rpi_load, rpi_start;
   logic [127:0] blk_data;
   logic         blk_valid, blk_ready, blk_first;
   logic         overflow, timeout_err, rx_busy;

   always #5 clk = ~clk;

   rpi_byte_collector #(
      .NBYTES      (16),
      .SYNC_STAGES (2),
      .TIMEOUT_CYC (TMO),
      .DEBOUNCE_CYC(DEB)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .rpi_data   (rpi_data),
      .rpi_load   (rpi_load),
      .rpi_start  (rpi_start),
      .blk_data   (blk_data),
      .blk_valid  (blk_valid),
      .blk_ready  (blk_ready),
      .blk_first  (blk_first),
      .overflow   (overflow),
      .timeout_err(timeout_err),
      .rx_busy    (rx_busy)
   );

   typedef struct packed {
      logic         first;
      logic [127:0] data;
   } blk_t;

   blk_t         sb[$];
   int           passed = 0;
   int           total = 0;
   int           vcyc = 0;
   int           hold_cyc = 6;
   int           mcnt = 0;
   logic         mfirst = 1'b1;
   logic [127:0] mbuf = '0;

   task automatic chk(input string tag, input logic [135:0] obs,
                      input logic [135:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   always @(negedge clk) begin
      blk_t e;
      if (blk_valid) vcyc++;
      if (blk_valid && blk_ready) begin
         total++;
         assert (sb.size() > 0) passed++;
         else $error("FAIL sb_underflow: observed 0 queued expected >=1");
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("blk_out", {7'b0, blk_first, blk_data}, {7'b0, e.first, e.data});
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      if (!(sb.size() >= 2 && mcnt == 0)) begin
         mbuf = {mbuf[119:0], b};
         mcnt++;
         if (mcnt == 16) begin
            sb.push_back({mfirst, mbuf});
            mfirst = 1'b0;
            mcnt = 0;
         end
      end
      rpi_data = b;
      rpi_load = 1'b1;
      repeat (hold_cyc) @(posedge clk);
      #1 rpi_load = 1'b0;
      repeat (hold_cyc) @(posedge clk);
      #1;
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: observed no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0;
      rpi_data = '0;
      rpi_load = 1'b0;
      rpi_start = 1'b0;
      blk_ready = 1'b0;
`ifdef LOAD_DEBOUNCE_EN
      hold_cyc = 2 * DEB;
`endif
      wait_cyc(3);
      chk("rst_valid", blk_valid, 0);
      chk("rst_data", blk_data, 0);
      chk("rst_flags", {blk_first, overflow, timeout_err, rx_busy}, 0);
      reset = 1'b1;
      wait_cyc(2);

      blk_ready = 1'b1;
      vcyc = 0;
      for (int i = 0; i < 16; i++) send_byte(8'(i));
      wait_cyc(10);
      chk("t1_valid_1cyc", vcyc, 1);
      chk("t1_sb_empty", sb.size(), 0);

      blk_ready = 1'b0;
      for (int i = 0; i < 32; i++) send_byte(8'(8'h10 + i));
      chk("t2_sb_depth", sb.size(), 2);
      chk("t2_valid", blk_valid, 1);
      chk("t2_data", blk_data, 128'h101112131415161718191A1B1C1D1E1F);
      chk("t2_first", blk_first, 0);
      chk("t2_hold", dut.state_q, ST_HOLD);
      chk("t2_ovf0", overflow, 0);
      send_byte(8'hEE);
      chk("t2_ovf1", overflow, 1);
      chk("t2_data_stable", blk_data, 128'h101112131415161718191A1B1C1D1E1F);
      blk_ready = 1'b1;
      wait_cyc(10);
      chk("t2_drained", sb.size(), 0);
      chk("t2_valid_low", blk_valid, 0);

      for (int i = 0; i < 5; i++) send_byte(8'(8'h50 + i));
      chk("t3_busy", rx_busy, 1);
      wait_cyc(TMO + 20);
      mcnt = 0;
      chk("t3_tmo", timeout_err, 1);
      chk("t3_busy0", rx_busy, 0);
      for (int i = 0; i < 16; i++) send_byte(8'(8'h60 + i));
      wait_cyc(10);
      chk("t3_sb_empty", sb.size(), 0);
      chk("t3_ovf_sticky", overflow, 1);

      for (int i = 0; i < 7; i++) send_byte(8'(8'h70 + i));
      rpi_start = 1'b1;
      wait_cyc(6);
      rpi_start = 1'b0;
      wait_cyc(6);
      mcnt = 0;
      mfirst = 1'b1;
      chk("t4_flags_clr", {overflow, timeout_err, rx_busy}, 0);
      blk_ready = 1'b0;
      for (int i = 0; i < 16; i++) send_byte(8'(8'hA0 + i));
      chk("t4_data", blk_data, 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF);
      chk("t4_first", blk_first, 1);
      blk_ready = 1'b1;
      wait_cyc(10);
      chk("t4_sb_empty", sb.size(), 0);

      for (int i = 0; i < 8; i++) send_byte(8'(8'hC0 + i));
      chk("t5_busy", rx_busy, 1);
      @(posedge clk);
      #3 reset = 1'b0;
      #1;
      chk("t5_async_data", blk_data, 0);
      chk("t5_async_flags",
          {blk_valid, blk_first, overflow, timeout_err, rx_busy}, 0);
      @(posedge clk);
      #1 reset = 1'b1;
      mcnt = 0;
      mfirst = 1'b1;
      sb.delete();
      wait_cyc(2);
      chk("t5_cnt", dut.cnt_q, 0);
      for (int i = 0; i < 16; i++) send_byte(8'(8'hD0 + i));
      wait_cyc(10);
      chk("t5_sb_empty", sb.size(), 0);

`ifdef LOAD_DEBOUNCE_EN
      rpi_data = 8'h33;
      rpi_load = 1'b1;
      wait_cyc(10);
      rpi_load = 1'b0;
      wait_cyc(3 * DEB);
      chk("t6_glitch_cnt", dut.cnt_q, 0);
      send_byte(8'h5A);
      chk("t6_clean_cnt", dut.cnt_q, mcnt);
      chk("t6_busy", rx_busy, 1);
`endif

      chk("final_sb_empty", sb.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
